// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - packs RV32 fields into instruction words, streamed from a small FIFO.
// Define ENCODER_UJ_EN to enable U (format 4) and J (format 5) encodings.
module instruction_encoder #(
  parameter int                DEPTH  = 4,
  parameter int                ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_format,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic [31:0]   enc_instr;
  logic          enc_err;
  logic signed [31:0] simm;

  assign simm = in_imm;

  always_comb begin
    enc_instr = 32'h0000_0013;
    enc_err   = 1'b0;
    case (in_format)
      3'd0: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      3'd1: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = (simm < -2048) || (simm > 2047);
      end
      3'd2: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err   = (simm < -2048) || (simm > 2047);
      end
      3'd3: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_err   = (simm < -4096) || (simm > 4094) || in_imm[0];
      end
`ifdef ENCODER_UJ_EN
      3'd4: enc_instr = {in_imm[31:12], in_rd, in_opcode};
      3'd5: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err   = (simm < -(32'sd1 <<< 20)) || (simm > ((32'sd1 <<< 20) - 2)) || in_imm[0];
      end
`endif
      default: begin
        enc_instr = 32'h0000_0013;
        enc_err   = 1'b1;
      end
    endcase
  end

  // Readiness comes from the registered count, so a pop frees its slot one cycle later.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? mem[rd_ptr][31:0] : 32'h0;
  assign out_err   = out_valid ? mem[rd_ptr][32] : 1'b0;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {enc_err, enc_instr};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_addr  <= BASE;
      err_count <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        out_addr <= out_addr + ADDR_W'(4);
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (push && enc_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - table vectors, corner sequences and random traffic against a field-level model.
module tb_instruction_encoder;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [2:0]  in_format;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  instruction_encoder #(.DEPTH(DEPTH), .ADDR_W(32), .BASE(32'h0)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_format(in_format), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  logic [32:0] q[$];
  logic [31:0] exp_addr;
  int          exp_errs;
  bit          last_push;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding built from shifts/masks of the field definitions.
  function automatic logic [32:0] ref_enc(input int fmt, input longint op, input longint rd,
                                          input longint rs1, input longint rs2, input longint f3,
                                          input longint f7, input logic [31:0] imm);
    longint u = imm;
    longint s = $signed(imm);
    longint w;
    bit     e = 0;
    case (fmt)
      0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      1: begin
        w = ((u & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        e = (s < -2048) || (s > 2047);
      end
      2: begin
        w = (((u >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((u & 'h1F) << 7) | op;
        e = (s < -2048) || (s > 2047);
      end
      3: begin
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (rs2 << 20) | (rs1 << 15) |
            (f3 << 12) | (((u >> 1) & 'hF) << 8) | (((u >> 11) & 1) << 7) | op;
        e = (s < -4096) || (s > 4094) || (s % 2 != 0);
      end
`ifdef ENCODER_UJ_EN
      4: w = (u & 'hFFFF_F000) | (rd << 7) | op;
      5: begin
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21) | (((u >> 11) & 1) << 20) |
            (((u >> 12) & 'hFF) << 12) | (rd << 7) | op;
        e = (s < -1048576) || (s > 1048574) || (s % 2 != 0);
      end
`endif
      default: begin w = 'h13; e = 1; end
    endcase
    return {e, w[31:0]};
  endfunction

  task automatic check_outputs();
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("out_valid", out_valid, q.size() > 0);
    chk("out_addr", out_addr, exp_addr);
    chk("err_count", err_count, exp_errs);
    if (q.size() > 0) begin
      chk("out_instr", out_instr, q[0][31:0]);
      chk("out_err", out_err, q[0][32]);
    end
  endtask

  task automatic cycle();
    bit push, pop;
    logic [32:0] e;
    push = in_valid && (q.size() < DEPTH);
    pop  = (q.size() > 0) && out_ready;
    e = ref_enc(in_format, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
    @(posedge clock);
    #1;
    if (pop) begin
      void'(q.pop_front());
      exp_addr += 4;
    end
    if (push) begin
      q.push_back(e);
      if (e[32] && exp_errs < 255) exp_errs++;
    end
    last_push = push;
    check_outputs();
  endtask

  task automatic model_reset();
    q.delete();
    exp_addr = 32'h0;
    exp_errs = 0;
  endtask

  task automatic set_fields(input vec_t v);
    in_format = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1;
    in_rs2 = v.rs2; in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
  endtask

  task automatic rand_fields();
    in_format = 3'($urandom_range(0, 7));
    in_opcode = 7'($urandom); in_rd = 5'($urandom); in_rs1 = 5'($urandom);
    in_rs2 = 5'($urandom); in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
    case ($urandom_range(0, 3))
      0: in_imm = $urandom;
      1: in_imm = 32'($urandom_range(0, 10000)) - 32'd5000;
      2: in_imm = 32'($urandom_range(0, 2200000)) - 32'd1100000;
      default: in_imm = {$urandom_range(0, 1) == 1 ? 20'hFFFFF : 20'h0, 12'($urandom)};
    endcase
  endtask

  function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] ei, input logic ee);
    vec_t v;
    v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.exp_instr = ei; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    vec_t v;
    tbl.push_back(mk(1, 7'h13, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFF0_0093, 0));
    tbl.push_back(mk(2, 7'h23, 0, 1, 2, 2, 0, 32'd8,         32'h0020_A423, 0));
    tbl.push_back(mk(3, 7'h63, 0, 0, 0, 0, 0, -32'sd4,       32'hFE00_0EE3, 0));
    tbl.push_back(mk(1, 7'h13, 0, 0, 0, 0, 0, 32'd2048,      32'h8000_0013, 1));
    tbl.push_back(mk(3, 7'h63, 0, 0, 0, 0, 0, 32'd6,         32'h0000_0363, 0));
    tbl.push_back(mk(3, 7'h63, 0, 0, 0, 0, 0, 32'd5,         32'h0000_0263, 1));
    tbl.push_back(mk(0, 7'h33, 1, 2, 3, 0, 7'h20, 32'd0,     32'h4031_00B3, 0));
`ifdef ENCODER_UJ_EN
    tbl.push_back(mk(4, 7'h37, 5, 0, 0, 0, 0, 32'h1234_5000, 32'h1234_52B7, 0));
`else
    tbl.push_back(mk(4, 7'h37, 5, 0, 0, 0, 0, 32'h1234_5000, 32'h0000_0013, 1));
`endif
    tbl.push_back(mk(7, 7'h33, 1, 2, 3, 0, 0, 32'd0,         32'h0000_0013, 1));
    tbl.push_back(mk(1, 7'h13, 0, 0, 0, 0, 0, -32'sd2048,    32'h8000_0013, 0));
    tbl.push_back(mk(2, 7'h23, 0, 0, 0, 0, 0, -32'sd2049,    32'h7E00_0FA3, 1));
    tbl.push_back(mk(3, 7'h63, 0, 0, 0, 0, 0, 32'd4094,      32'h7E00_0FE3, 0));
    tbl.push_back(mk(3, 7'h63, 0, 0, 0, 0, 0, 32'd4096,      32'h8000_0063, 1));

    reset = 1'b1; in_valid = 0; out_ready = 0;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fields(v);
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_in_ready", in_ready, 1);

    // Table vectors, one at a time through an empty FIFO.
    foreach (tbl[i]) begin
      set_fields(tbl[i]);
      in_valid = 1; out_ready = 0;
      cycle();
      in_valid = 0;
      chk("tbl_instr", out_instr, tbl[i].exp_instr);
      chk("tbl_err", out_err, tbl[i].exp_err);
      out_ready = 1;
      cycle();
    end
    out_ready = 0;

    // Backpressure: fill, confirm stall, then drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1; rand_fields();
      cycle();
    end
    chk("full_in_ready", in_ready, 0);
    rand_fields();
    repeat (2) cycle();
    in_valid = 0; out_ready = 1;
    repeat (DEPTH + 1) cycle();
    chk("drain_empty", out_valid, 0);

    // Asynchronous reset with three entries queued.
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin rand_fields(); cycle(); end
    in_valid = 0;
    #2 reset = 1'b1;
    #1;
    chk("amid_out_valid", out_valid, 0);
    chk("amid_out_addr", out_addr, 0);
    chk("amid_err_count", err_count, 0);
    #1 reset = 1'b0;
    model_reset();
    cycle();

    // err_count saturation.
    v = mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fields(v);
    in_valid = 1; out_ready = 1;
    repeat (262) cycle();
    chk("sat_err_count", err_count, 255);
    in_valid = 0;
    cycle();
    model_reset();
    reset = 1'b1;
    #1 reset = 1'b0;

    // Random traffic; fields held while an offered request stalls.
    for (int n = 0; n < 600; n++) begin
      if (!(in_valid && !last_push)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_fields();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
